// File: rtl/riscv_isa_pkg.sv
// Shared RV32I constants: base opcodes, the immediate format codes that
// IMM_EXTENDER understands, the NOP instruction and the IF/ID beat record.
package riscv_isa_pkg;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Immediate format codes; must match IMM_EXTENDER
    localparam logic [2:0] I_FORMAT  = 3'b000;
    localparam logic [2:0] S_FORMAT  = 3'b001;
    localparam logic [2:0] U_FORMAT  = 3'b010;
    localparam logic [2:0] SB_FORMAT = 3'b011;
    localparam logic [2:0] UJ_FORMAT = 3'b100;
    localparam logic [2:0] R_FORMAT  = 3'b111;

    // addi x0,x0,0 shown on the decode side while nothing is valid
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One fetch beat plus its pre-decoded format, stored together
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic        illegal;
    } beat_t;

    localparam beat_t NOP_BEAT = '{pc: 32'h0, instr: NOP_INSTR, fmt: I_FORMAT, illegal: 1'b0};

endpackage

// File: rtl/imm_format_decoder.sv
// Combinational opcode -> {immediate format, illegal} pre-decode.
module imm_format_decoder
    import riscv_isa_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] format,
    output logic       illegal
);

    // Classify the opcode into the IMM_EXTENDER format code
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
        format  = R_FORMAT;
        illegal = 1'b1;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: begin
                format  = I_FORMAT;
                illegal = 1'b0;
            end
            OP_STORE: begin
                format  = S_FORMAT;
                illegal = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                format  = U_FORMAT;
                illegal = 1'b0;
            end
            OP_BRANCH: begin
                format  = SB_FORMAT;
                illegal = 1'b0;
            end
            OP_JAL: begin
                format  = UJ_FORMAT;
                illegal = 1'b0;
            end
            OP_REG: begin
                format  = R_FORMAT;
                illegal = 1'b0;
            end
            default: begin
                format  = R_FORMAT;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/if_id_stage_buffer.sv
// IF->ID pipeline stage: 2-entry skid buffer (MAIN drives decode, SKID holds
// overflow) with format pre-decode at enqueue, stall and flush support.
module if_id_stage_buffer
    import riscv_isa_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        IF_VALID,
    output logic        IF_READY,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_INSTR,
    output logic        ID_VALID,
    input  logic        ID_READY,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_INSTR,
    output logic [24:0] ID_IMM_INPUT,
    output logic [2:0]  ID_IMM_FORMAT,
    output logic [4:0]  ID_RS1,
    output logic [4:0]  ID_RS2,
    output logic [4:0]  ID_RD,
    output logic        ID_ILLEGAL
);

    logic       main_valid;
    logic       skid_valid;
    beat_t      main_q;
    beat_t      skid_q;
    beat_t      in_beat;
    logic [2:0] in_fmt;
    logic       in_illegal;
    logic       accept;
    logic       pop;
    logic       skid_load;

    imm_format_decoder u_decoder (
        .opcode  (IF_INSTR[6:0]),
        .format  (in_fmt),
        .illegal (in_illegal)
    );

    assign in_beat = '{pc: IF_PC, instr: IF_INSTR, fmt: in_fmt, illegal: in_illegal};

    // IF_READY is simply the inverse of a register bit, so it is registered.
    assign IF_READY  = ~skid_valid;
    assign accept    = IF_VALID & IF_READY & ~FLUSH;
    assign pop       = main_valid & ID_READY;
    // Accepted beat goes to SKID whenever MAIN is occupied after this edge.
    assign skid_load = accept & main_valid & (~pop | skid_valid);

    // MAIN entry and both valid bits: reset/flush, refill from SKID or input, or hold
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (RST || FLUSH) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= NOP_BEAT;
        end else if (pop && skid_valid) begin
            main_q     <= skid_q;
            skid_valid <= accept;
        end else if (!main_valid || pop) begin
            if (accept) begin
                main_q     <= in_beat;
                main_valid <= 1'b1;
            end else begin
                main_q     <= NOP_BEAT;
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
        end
    end

    // SKID payload capture on overflow
    always_ff @(posedge CLK) begin
        // NOTE: payload is not reset; it is only observed after skid_valid is set, which rewrites it.
        if (skid_load) begin
            skid_q <= in_beat;
        end
    end

    assign ID_VALID      = main_valid;
    assign ID_PC         = main_q.pc;
    assign ID_INSTR      = main_q.instr;
    assign ID_IMM_INPUT  = main_q.instr[31:7];
    assign ID_IMM_FORMAT = main_q.fmt;
    assign ID_RS1        = main_q.instr[19:15];
    assign ID_RS2        = main_q.instr[24:20];
    assign ID_RD         = main_q.instr[11:7];
    assign ID_ILLEGAL    = main_q.illegal;

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Self-checking bench for if_id_stage_buffer: directed sequences, an opcode
// table, and randomized traffic against a queue-based reference model.
module tb_if_id_stage_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [24:0] id_imm_input;
    logic [2:0]  id_imm_format;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_id_stage_buffer dut (
        .CLK           (clk),
        .RST           (rst),
        .FLUSH         (flush),
        .IF_VALID      (if_valid),
        .IF_READY      (if_ready),
        .IF_PC         (if_pc),
        .IF_INSTR      (if_instr),
        .ID_VALID      (id_valid),
        .ID_READY      (id_ready),
        .ID_PC         (id_pc),
        .ID_INSTR      (id_instr),
        .ID_IMM_INPUT  (id_imm_input),
        .ID_IMM_FORMAT (id_imm_format),
        .ID_RS1        (id_rs1),
        .ID_RS2        (id_rs2),
        .ID_RD         (id_rd),
        .ID_ILLEGAL    (id_illegal)
    );

    // Reference model: an in-order queue of at most two beats
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } mbeat_t;
    mbeat_t mq[$];

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {format, illegal} from the opcode table
    function automatic logic [3:0] exp_decode(input logic [31:0] ins);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: exp_decode = {3'b000, 1'b0};
            7'h23:                             exp_decode = {3'b001, 1'b0};
            7'h37, 7'h17:                      exp_decode = {3'b010, 1'b0};
            7'h63:                             exp_decode = {3'b011, 1'b0};
            7'h6F:                             exp_decode = {3'b100, 1'b0};
            7'h33:                             exp_decode = {3'b111, 1'b0};
            default:                           exp_decode = {3'b111, 1'b1};
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sampled
    task automatic model_step();
        bit acc;
        bit pp;
        if (rst || flush) begin
            mq.delete();
        end else begin
            acc = if_valid && (mq.size() < 2);
            pp  = (mq.size() > 0) && id_ready;
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back('{pc: if_pc, instr: if_instr});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic compare_model(input string tag);
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [3:0]  ed;
        ev = (mq.size() > 0);
        ei = ev ? mq[0].instr : 32'h0000_0013;
        ep = ev ? mq[0].pc : 32'h0;
        ed = exp_decode(ei);
        check({tag, ".id_valid"}, 64'(id_valid), 64'(ev));
        check({tag, ".if_ready"}, 64'(if_ready), 64'(mq.size() < 2));
        check({tag, ".id_pc"}, 64'(id_pc), 64'(ep));
        check({tag, ".id_instr"}, 64'(id_instr), 64'(ei));
        check({tag, ".imm_input"}, 64'(id_imm_input), 64'(ei[31:7]));
        check({tag, ".fmt_ill"}, 64'({id_imm_format, id_illegal}), 64'(ed));
        check({tag, ".regs"}, 64'({id_rs1, id_rs2, id_rd}), 64'({ei[19:15], ei[24:20], ei[11:7]}));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        if_valid = 1'b0;
        id_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".id_valid"}, 64'(id_valid), 64'(0));
        check({tag, ".id_pc"}, 64'(id_pc), 64'(0));
        check({tag, ".id_instr"}, 64'(id_instr), 64'h13);
        check({tag, ".fmt"}, 64'(id_imm_format), 64'(0));
        check({tag, ".illegal"}, 64'(id_illegal), 64'(0));
        check({tag, ".if_ready"}, 64'(if_ready), 64'(1));
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  ops[12];

        vecs[0]  = '{32'hFFF00093, 3'b000, 1'b0};
        vecs[1]  = '{32'h00112623, 3'b001, 1'b0};
        vecs[2]  = '{32'h00208463, 3'b011, 1'b0};
        vecs[3]  = '{32'h008000EF, 3'b100, 1'b0};
        vecs[4]  = '{32'h123450B7, 3'b010, 1'b0};
        vecs[5]  = '{32'h002081B3, 3'b111, 1'b0};
        vecs[6]  = '{32'h0000007F, 3'b111, 1'b1};
        vecs[7]  = '{32'h00000097, 3'b010, 1'b0};
        vecs[8]  = '{32'h00002083, 3'b000, 1'b0};
        vecs[9]  = '{32'h000080E7, 3'b000, 1'b0};
        vecs[10] = '{32'h00000073, 3'b000, 1'b0};
        vecs[11] = '{32'h0000000F, 3'b000, 1'b0};

        if_pc = 32'h0;
        if_instr = 32'h0;
        do_reset();
        check_reset_values("reset");

        // 1. single addi beat
        id_ready = 1'b1;
        if_valid = 1'b1;
        if_pc = 32'h100;
        if_instr = 32'hFFF00093;
        tick();
        if_valid = 1'b0;
        check("t1.id_valid", 64'(id_valid), 64'(1));
        check("t1.id_pc", 64'(id_pc), 64'h100);
        check("t1.imm_input", 64'(id_imm_input), 64'h1FFE001);
        check("t1.fmt", 64'(id_imm_format), 64'(0));
        check("t1.rd", 64'(id_rd), 64'(1));
        tick();

        // 2. back-to-back stream of 8 beats
        if_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if_pc = 32'h200 + 32'(4 * k);
            if_instr = 32'h00000013 | (32'(k) << 7);
            tick();
            check("t2.id_valid", 64'(id_valid), 64'(1));
            check("t2.id_pc", 64'(id_pc), 64'(32'h200 + 32'(4 * k)));
            check("t2.if_ready", 64'(if_ready), 64'(1));
        end
        if_valid = 1'b0;
        tick();
        check("t2.drain", 64'(id_valid), 64'(0));

        // 3. stall with sw then beq
        id_ready = 1'b0;
        if_valid = 1'b1;
        if_pc = 32'h300;
        if_instr = 32'h00112623;
        tick();
        check("t3.ready1", 64'(if_ready), 64'(1));
        if_pc = 32'h304;
        if_instr = 32'h00208463;
        tick();
        if_valid = 1'b0;
        check("t3.ready2", 64'(if_ready), 64'(0));
        check("t3.sw_fmt", 64'(id_imm_format), 64'(1));
        tick();
        check("t3.hold_pc", 64'(id_pc), 64'h300);
        check("t3.hold_instr", 64'(id_instr), 64'h00112623);
        id_ready = 1'b1;
        tick();
        check("t3.beq_pc", 64'(id_pc), 64'h304);
        check("t3.beq_fmt", 64'(id_imm_format), 64'(3));
        check("t3.ready3", 64'(if_ready), 64'(1));
        tick();

        // 4. flush with both entries full and a beat offered
        id_ready = 1'b0;
        if_valid = 1'b1;
        if_pc = 32'h400; if_instr = 32'h00100093; tick();
        if_pc = 32'h404; if_instr = 32'h00200093; tick();
        check("t4.full", 64'(if_ready), 64'(0));
        flush = 1'b1;
        if_pc = 32'h4AA; if_instr = 32'h00300093;
        tick();
        flush = 1'b0;
        if_valid = 1'b0;
        check("t4.id_valid", 64'(id_valid), 64'(0));
        check("t4.id_instr", 64'(id_instr), 64'h13);
        check("t4.if_ready", 64'(if_ready), 64'(1));
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4.gone", 64'(id_valid), 64'(0));
        end

        // 5. opcode table
        for (int i = 0; i < 12; i++) begin
            if_valid = 1'b1;
            if_pc = 32'h500 + 32'(4 * i);
            if_instr = vecs[i].instr;
            tick();
            if_valid = 1'b0;
            check($sformatf("t5.instr[%0d]", i), 64'(id_instr), 64'(vecs[i].instr));
            check($sformatf("t5.fmt[%0d]", i), 64'(id_imm_format), 64'(vecs[i].fmt));
            check($sformatf("t5.ill[%0d]", i), 64'(id_illegal), 64'(vecs[i].ill));
            tick();
        end

        // 6. reset mid-stall with SKID full
        id_ready = 1'b0;
        if_valid = 1'b1;
        if_pc = 32'h600; if_instr = 32'h0000007F; tick();
        if_pc = 32'h604; if_instr = 32'h00112623; tick();
        if_valid = 1'b0;
        check("t6.full", 64'(if_ready), 64'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("t6");

        // Randomized traffic against the queue model
        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h33, 7'h7F};
        for (int n = 0; n < 800; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            if_valid = ($urandom_range(0, 3) != 0);
            id_ready = ($urandom_range(0, 2) != 0);
            r        = $urandom;
            if_pc    = $urandom;
            if ($urandom_range(0, 7) == 0)
                if_instr = r;
            else
                if_instr = {r[31:7], ops[$urandom_range(0, 11)]};
            tick();
            compare_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
